pb_key_mailbox: RTL and testbench

- Port-mapped, multi-channel mailbox between a producer PicoBlaze (key generator) and a consumer PicoBlaze (cipher core).
- Replaces the single key register and single interrupt flop with NUM_CH buffered FIFO channels, status readback and a re-arming interrupt.
- Sits between the producer's port_id/out_port/write_strobe and the consumer's port_id/in_port/read_strobe/interrupt pins.

---
 rtl/pb_mailbox_pkg.sv | 13 +
 rtl/pb_key_mailbox_if.sv | 19 +
 rtl/pb_mailbox_fifo.sv | 48 ++++
 rtl/pb_key_mailbox.sv | 70 +++++++
 tb/tb_pb_key_mailbox.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pb_mailbox_pkg.sv
// pb_mailbox_pkg: shared port addresses, channel index type and clog2 helper for the key mailbox.
package pb_mailbox_pkg;
  localparam logic [7:0] STATUS_PORT = 8'h80;
  localparam logic [7:0] OVF_PORT = 8'h81;
  localparam int DATA_SEL_BIT = 7;
  typedef logic [DATA_SEL_BIT-1:0] ch_idx_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pb_key_mailbox_if.sv
// pb_key_mailbox_if: producer write port and consumer read/interrupt pins of the PicoBlaze pair.
interface pb_key_mailbox_if #(parameter int DATA_W = 8);
  logic [7:0] prod_port_id;
  logic [DATA_W-1:0] prod_out_port;
  logic prod_write_strobe;
  logic [7:0] cons_port_id;
  logic cons_read_strobe;
  logic [DATA_W-1:0] cons_in_port;
  logic cons_interrupt;
  logic cons_interrupt_ack;
  modport master (
    output prod_port_id, prod_out_port, prod_write_strobe, cons_port_id, cons_read_strobe, cons_interrupt_ack,
    input cons_in_port, cons_interrupt
  );
  modport slave (
    input prod_port_id, prod_out_port, prod_write_strobe, cons_port_id, cons_read_strobe, cons_interrupt_ack,
    output cons_in_port, cons_interrupt
  );
endinterface

// File: rtl/pb_mailbox_fifo.sv
// pb_mailbox_fifo: single-channel synchronous FIFO; full/empty judged on the pre-cycle count.
module pb_mailbox_fifo
  import pb_mailbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic empty_o,
  output logic full_o,
  output logic [clog2(DEPTH):0] count_o
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok = pop_i && !empty_o;
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage is deliberately left uncleared by reset; the pointers alone define validity
  always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/pb_key_mailbox.sv
// pb_key_mailbox: NUM_CH buffered key channels from producer to consumer PicoBlaze with status and re-arming interrupt.
// Define PB_MAILBOX_OVF_STATUS_EN to add per-channel sticky overflow flags readable at OVF_PORT.
module pb_key_mailbox
  import pb_mailbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pb_key_mailbox_if.slave bus,
  output logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_full
);
  localparam int CW = clog2(DEPTH) + 1;
  ch_idx_t prod_ch, cons_ch;
  logic prod_hit, cons_hit, any_push, any_busy, int_q, int_d, ack_q;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [NUM_CH-1:0] push, pop, busy;
  logic [DATA_W-1:0] heads [NUM_CH];
  logic [CW-1:0] cnt [NUM_CH];
  assign prod_ch = bus.prod_port_id[DATA_SEL_BIT-1:0];
  assign cons_ch = bus.cons_port_id[DATA_SEL_BIT-1:0];
  assign prod_hit = !bus.prod_port_id[DATA_SEL_BIT] && prod_ch < ch_idx_t'(NUM_CH);
  assign cons_hit = !bus.cons_port_id[DATA_SEL_BIT] && cons_ch < ch_idx_t'(NUM_CH);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push[g] = bus.prod_write_strobe && prod_hit && prod_ch == ch_idx_t'(g);
    assign pop[g] = bus.cons_read_strobe && cons_hit && cons_ch == ch_idx_t'(g);
    assign busy[g] = |cnt[g];
    pb_mailbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push_i(push[g]), .pop_i(pop[g]), .data_i(bus.prod_out_port),
      .head_o(heads[g]), .empty_o(ch_empty[g]), .full_o(ch_full[g]), .count_o(cnt[g])
    );
  end
  assign any_push = |(push & ~ch_full);
  assign any_busy = |busy;
`ifdef PB_MAILBOX_OVF_STATUS_EN
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  assign ovf_d = (ovf_q & ~{NUM_CH{bus.cons_read_strobe && bus.cons_port_id == OVF_PORT}}) | (push & ch_full);
  always_ff @(posedge clk) ovf_q <= reset ? '0 : ovf_d;
`endif
  always_comb begin
    rd_d = '0;
    if (bus.cons_port_id == STATUS_PORT) begin
      rd_d[NUM_CH-1:0] = ch_empty;
      rd_d[DATA_W/2 +: NUM_CH] = ch_full;
    end
`ifdef PB_MAILBOX_OVF_STATUS_EN
    if (bus.cons_port_id == OVF_PORT) rd_d[NUM_CH-1:0] = ovf_q;
`endif
    for (int i = 0; i < NUM_CH; i++)
      if (cons_hit && cons_ch == ch_idx_t'(i)) rd_d = ch_empty[i] ? '0 : heads[i];
  end
  // ack_q re-raises the request one cycle after an ack if keys are still queued
  assign int_d = any_push || (!bus.cons_interrupt_ack && (int_q || (ack_q && any_busy)));
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      int_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      int_q <= int_d;
      ack_q <= bus.cons_interrupt_ack;
    end
  end
  assign bus.cons_in_port = rd_q;
  assign bus.cons_interrupt = int_q;
endmodule

// File: tb/tb_pb_key_mailbox.sv
// tb_pb_key_mailbox: directed plus random stimulus checked against a queue-based mailbox model.
module tb_pb_key_mailbox;
  localparam int NUM_CH = 2;
  localparam int DEPTH = 4;
`ifdef PB_MAILBOX_OVF_STATUS_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] ch_empty, ch_full;
  pb_key_mailbox_if #(.DATA_W(8)) bus ();
  pb_key_mailbox #(.DATA_W(8), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .ch_empty(ch_empty), .ch_full(ch_full)
  );
  always #5 clk = ~clk;

  logic [7:0] q [NUM_CH][$];
  logic [NUM_CH-1:0] ovf;
  logic [7:0] exp_rd;
  bit exp_int, ack_prev;
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] e, f;
    for (int i = 0; i < NUM_CH; i++) begin
      e[i] = q[i].size() == 0;
      f[i] = q[i].size() == DEPTH;
    end
    check("cons_in_port", 32'(bus.cons_in_port), 32'(exp_rd));
    check("cons_interrupt", 32'(bus.cons_interrupt), 32'(exp_int));
    check("ch_empty", 32'(ch_empty), 32'(e));
    check("ch_full", 32'(ch_full), 32'(f));
  endtask

  task automatic step(input logic [7:0] pid, input logic [7:0] pd, input bit w,
                      input logic [7:0] cid, input bit r, input bit a);
    int pre [NUM_CH];
    int pc, cc;
    bit any, acc;
    @(negedge clk);
    bus.prod_port_id = pid;
    bus.prod_out_port = pd;
    bus.prod_write_strobe = w;
    bus.cons_port_id = cid;
    bus.cons_read_strobe = r;
    bus.cons_interrupt_ack = a;
    pc = int'(pid);
    cc = int'(cid);
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pre[i] = q[i].size();
      if (pre[i] > 0) any = 1'b1;
    end
    exp_rd = 8'h00;
    if (cc < NUM_CH) exp_rd = pre[cc] > 0 ? q[cc][0] : 8'h00;
    else if (cid == 8'h80)
      for (int i = 0; i < NUM_CH; i++) begin
        exp_rd[i] = pre[i] == 0;
        exp_rd[4 + i] = pre[i] == DEPTH;
      end
    else if (cid == 8'h81 && OVF_EN) exp_rd = 8'(ovf);
    if (r && cid == 8'h81) ovf = '0;
    if (r && cc < NUM_CH && pre[cc] > 0) void'(q[cc].pop_front());
    acc = 1'b0;
    if (w && pc < NUM_CH) begin
      if (pre[pc] < DEPTH) begin
        q[pc].push_back(pd);
        acc = 1'b1;
      end else ovf[pc] = 1'b1;
    end
    if (acc) exp_int = 1'b1;
    else if (a) exp_int = 1'b0;
    else if (ack_prev && any) exp_int = 1'b1;
    ack_prev = a;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic [7:0] cid, input bit r);
    step(8'h40, 8'h00, 1'b0, cid, r, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.prod_write_strobe = 1'b0;
    bus.cons_read_strobe = 1'b0;
    bus.cons_interrupt_ack = 1'b0;
    bus.prod_port_id = 8'h40;
    bus.cons_port_id = 8'h00;
    bus.prod_out_port = 8'h00;
    for (int i = 0; i < NUM_CH; i++) q[i].delete();
    ovf = '0;
    exp_rd = 8'h00;
    exp_int = 1'b0;
    ack_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    check("reset_empty", 32'(ch_empty), 32'h3);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ids [7];
    ids = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h80, 8'h81, 8'h40};
    do_reset();
    step(8'h00, 8'hA5, 1'b1, 8'h40, 1'b0, 1'b0);
    check("int_after_push", 32'(bus.cons_interrupt), 32'h1);
    idle(8'h80, 1'b0);
    check("status_one_key", 32'(bus.cons_in_port), 32'h02);
    idle(8'h00, 1'b0);
    idle(8'h00, 1'b1);
    check("pop_a5", 32'(bus.cons_in_port), 32'hA5);
    check("ch0_empty_after_pop", 32'(ch_empty[0]), 32'h1);
    step(8'h40, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1);
    idle(8'h40, 1'b0);
    for (int k = 0; k < 5; k++) step(8'h01, 8'(8'h11 + k), 1'b1, 8'h40, 1'b0, 1'b0);
    check("ch1_full", 32'(ch_full[1]), 32'h1);
    idle(8'h81, 1'b1);
    check("ovf_read", 32'(bus.cons_in_port), OVF_EN ? 32'h02 : 32'h00);
    idle(8'h81, 1'b0);
    check("ovf_cleared", 32'(bus.cons_in_port), 32'h00);
    for (int k = 0; k < 4; k++) begin
      idle(8'h01, 1'b0);
      idle(8'h01, 1'b1);
      check("drain_ch1", 32'(bus.cons_in_port), 32'(8'h11 + k));
    end
    idle(8'h01, 1'b0);
    check("lost_0x15", 32'(bus.cons_in_port), 32'h00);
    step(8'h00, 8'h22, 1'b1, 8'h40, 1'b0, 1'b0);
    idle(8'h00, 1'b0);
    step(8'h00, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);
    check("pushpop_old_head", 32'(bus.cons_in_port), 32'h22);
    check("pushpop_count", 32'(ch_empty[0]), 32'h0);
    idle(8'h00, 1'b0);
    check("pushpop_new_head", 32'(bus.cons_in_port), 32'h33);
    step(8'h00, 8'h44, 1'b1, 8'h40, 1'b0, 1'b1);
    check("push_beats_ack", 32'(bus.cons_interrupt), 32'h1);
    step(8'h40, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1);
    check("ack_clears", 32'(bus.cons_interrupt), 32'h0);
    idle(8'h40, 1'b0);
    check("rearm", 32'(bus.cons_interrupt), 32'h1);
    idle(8'h00, 1'b1);
    idle(8'h00, 1'b1);
    idle(8'h00, 1'b1);
    check("empty_read", 32'(bus.cons_in_port), 32'h00);
    step(8'h40, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1);
    idle(8'h40, 1'b0);
    step(8'h05, 8'h77, 1'b1, 8'h40, 1'b0, 1'b0);
    check("bad_port_no_int", 32'(bus.cons_interrupt), 32'h0);
    check("bad_port_no_push", 32'(ch_empty), 32'h3);
    step(8'h00, 8'h61, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'h01, 8'h62, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h63, 1'b1, 8'h00, 1'b0, 1'b0);
    do_reset();
    check("reset_rd", 32'(bus.cons_in_port), 32'h00);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step(ids[$urandom_range(0, 6)], 8'($urandom), 1'($urandom_range(0, 1)),
           ids[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
